// File: rtl/msi_directory_controller.sv
// MSI home directory: per-block state, sharer set and owner for NPROC caches.
// One request at a time walks lookup, invalidate/fetch and memory phases, then responds.
module msi_directory_controller #(
    parameter int NPROC         = 3,
    parameter int NBLK          = 8,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_ReqValid,
    output logic             o_ReqReady,
    input  logic [1:0]       i_ReqProc,
    input  logic [1:0]       i_ReqOp,
    input  logic [3:0]       i_ReqAddress,
    input  logic [3:0]       i_ReqData,
    output logic             o_MemValid,
    output logic             o_MemWrite,
    output logic [3:0]       o_MemAddress,
    output logic [3:0]       o_MemWriteData,
    input  logic             i_MemAck,
    input  logic [3:0]       i_MemReadData,
    output logic             o_InvValid,
    output logic [NPROC-1:0] o_InvMask,
    output logic             o_FetchValid,
    output logic [1:0]       o_FetchProc,
    output logic             o_FetchInv,
    input  logic             i_FetchAck,
    input  logic [3:0]       i_FetchData,
    output logic             o_RespValid,
    output logic [1:0]       o_RespProc,
    output logic [3:0]       o_RespAddress,
    output logic [3:0]       o_RespData,
    output logic             o_RespErr
);
    localparam int IW = $clog2(NBLK);
    localparam int CW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [3:0]    MAX_ADDR = 4'(NBLK);
    localparam logic [1:0]    MAX_PROC = 2'(NPROC);
    localparam logic [CW-1:0] TMO      = CW'(FETCH_TIMEOUT);
    localparam logic [1:0]    OP_RD = 2'b00;
    localparam logic [1:0]    OP_WR = 2'b01;
    localparam logic [1:0]    OP_WB = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_INV, S_FETCH, S_MEM_WB, S_MEM_RD, S_RESPOND
    } state_t;
    typedef enum logic [1:0] {D_I, D_S, D_M} dst_t;

    state_t           r_state, w_next;
    logic [1:0]       r_proc, r_op, r_fproc;
    logic [3:0]       r_addr, r_data;
    logic             r_err, r_finv;
    logic [CW-1:0]    r_cnt;
    logic [NPROC-1:0] r_mask;
    dst_t             r_dst [NBLK];
    logic [NPROC-1:0] r_shr [NBLK];
    logic [1:0]       r_own [NBLK];
    dst_t             r_nst;
    logic [NPROC-1:0] r_nshr;
    logic [1:0]       r_nown;

    logic [IW-1:0]    w_idx;
    dst_t             w_cur_st, w_nst;
    logic [NPROC-1:0] w_cur_shr, w_req_bit, w_own_bit, w_nshr;
    logic [1:0]       w_cur_own, w_nown;
    logic             w_is_own, w_bad, w_lk_err;
    logic             w_rd, w_wr, w_wb, w_mem, w_resp, w_commit;
    state_t           w_lk_next;
    logic [CW-1:0]    w_cnt_inc;

    assign w_rd      = (r_op == OP_RD);
    assign w_wr      = (r_op == OP_WR);
    assign w_wb      = (r_op == OP_WB);
    assign w_mem     = (r_state == S_MEM_RD) || (r_state == S_MEM_WB);
    assign w_resp    = (r_state == S_RESPOND);
    assign w_cnt_inc = r_cnt + 1'b1;
    // Every successful path ends in a memory phase, so its ack is the commit point.
    assign w_commit  = w_mem && i_MemAck;

    always_comb begin : lookup
        w_idx     = IW'(r_addr - 4'd1);
        w_cur_st  = r_dst[w_idx];
        w_cur_shr = r_shr[w_idx];
        w_cur_own = r_own[w_idx];
        w_req_bit = NPROC'(1) << r_proc;
        w_own_bit = NPROC'(1) << w_cur_own;
        w_is_own  = (w_cur_st == D_M) && (w_cur_own == r_proc);
        w_bad     = (r_addr == 4'd0) || (r_addr > MAX_ADDR) ||
                    (r_op == 2'b11) || (r_proc >= MAX_PROC);
        w_lk_next = S_RESPOND;
        w_lk_err  = 1'b1;
        w_nst     = w_cur_st;
        w_nshr    = w_cur_shr;
        w_nown    = w_cur_own;
        if (!w_bad) begin
            unique case (1'b1)
                w_rd && (w_cur_st == D_M) && !w_is_own: begin
                    w_lk_next = S_FETCH;
                    w_lk_err  = 1'b0;
                    w_nst     = D_S;
                    w_nshr    = w_own_bit | w_req_bit;
                end
                w_rd && ((w_cur_st == D_I) || (w_cur_st == D_S)): begin
                    w_lk_next = S_MEM_RD;
                    w_lk_err  = 1'b0;
                    w_nst     = D_S;
                    w_nshr    = ((w_cur_st == D_S) ? w_cur_shr : '0) | w_req_bit;
                end
                w_wr && (w_cur_st == D_M) && !w_is_own: begin
                    w_lk_next = S_FETCH;
                    w_lk_err  = 1'b0;
                    w_nst     = D_M;
                    w_nshr    = w_req_bit;
                    w_nown    = r_proc;
                end
                w_wr && ((w_cur_st == D_I) || (w_cur_st == D_S)): begin
                    w_lk_next = (w_cur_st == D_S) ? S_INV : S_MEM_RD;
                    w_lk_err  = 1'b0;
                    w_nst     = D_M;
                    w_nshr    = w_req_bit;
                    w_nown    = r_proc;
                end
                w_wb && w_is_own: begin
                    w_lk_next = S_MEM_WB;
                    w_lk_err  = 1'b0;
                    w_nst     = D_I;
                    w_nshr    = '0;
                    w_nown    = 2'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin : next_state
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_ReqValid) w_next = S_LOOKUP;
            S_LOOKUP:  w_next = w_lk_next;
            S_INV:     w_next = S_MEM_RD;
            S_FETCH: begin
                if (i_FetchAck)              w_next = S_MEM_WB;
                else if (w_cnt_inc == TMO)   w_next = S_RESPOND;
            end
            S_MEM_WB, S_MEM_RD: if (i_MemAck) w_next = S_RESPOND;
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
            r_proc  <= '0;
            r_op    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_finv  <= 1'b0;
            r_fproc <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_nst   <= D_I;
            r_nshr  <= '0;
            r_nown  <= '0;
            for (int i = 0; i < NBLK; i++) begin
                r_dst[i] <= D_I;
                r_shr[i] <= '0;
                r_own[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (i_ReqValid) begin
                    r_proc <= i_ReqProc;
                    r_op   <= i_ReqOp;
                    r_addr <= i_ReqAddress;
                    r_data <= i_ReqData;
                end
                S_LOOKUP: begin
                    r_err   <= w_lk_err;
                    r_nst   <= w_nst;
                    r_nshr  <= w_nshr;
                    r_nown  <= w_nown;
                    r_cnt   <= '0;
                    r_mask  <= w_cur_shr & ~w_req_bit;
                    r_finv  <= w_wr;
                    r_fproc <= w_cur_own;
                end
                S_FETCH: begin
                    if (i_FetchAck) begin
                        r_data <= i_FetchData;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == TMO) r_err <= 1'b1;
                    end
                end
                S_MEM_RD: if (i_MemAck) r_data <= i_MemReadData;
                default: ;
            endcase
            if (w_commit) begin
                r_dst[w_idx] <= r_nst;
                r_shr[w_idx] <= r_nshr;
                r_own[w_idx] <= r_nown;
            end
        end
    end

    always_comb begin : outputs
        o_ReqReady     = (r_state == S_IDLE) && !i_Reset;
        o_MemValid     = w_mem;
        o_MemWrite     = (r_state == S_MEM_WB);
        o_MemAddress   = w_mem ? r_addr : '0;
        o_MemWriteData = (r_state == S_MEM_WB) ? r_data : '0;
        o_InvValid     = (r_state == S_INV) && (r_mask != '0);
        o_InvMask      = (r_state == S_INV) ? r_mask : '0;
        o_FetchValid   = (r_state == S_FETCH);
        o_FetchProc    = (r_state == S_FETCH) ? r_fproc : '0;
        o_FetchInv     = (r_state == S_FETCH) && r_finv;
        o_RespValid    = w_resp;
        o_RespProc     = w_resp ? r_proc : '0;
        o_RespAddress  = w_resp ? r_addr : '0;
        o_RespData     = w_resp ? r_data : '0;
        o_RespErr      = w_resp && r_err;
    end
endmodule

// File: tb/tb_msi_directory_controller.sv
// Randomised bench for the MSI directory against a per-block state/sharer/owner model.
// Plays the memory and owner-cache roles and scores every transaction.
module tb_msi_directory_controller;
    logic       clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_ReqValid = 1'b0;
    logic       o_ReqReady;
    logic [1:0] i_ReqProc = '0;
    logic [1:0] i_ReqOp = '0;
    logic [3:0] i_ReqAddress = '0;
    logic [3:0] i_ReqData = '0;
    logic       o_MemValid, o_MemWrite;
    logic [3:0] o_MemAddress, o_MemWriteData;
    logic       i_MemAck = 1'b0;
    logic [3:0] i_MemReadData = '0;
    logic       o_InvValid;
    logic [2:0] o_InvMask;
    logic       o_FetchValid;
    logic [1:0] o_FetchProc;
    logic       o_FetchInv;
    logic       i_FetchAck = 1'b0;
    logic [3:0] i_FetchData = '0;
    logic       o_RespValid;
    logic [1:0] o_RespProc;
    logic [3:0] o_RespAddress, o_RespData;
    logic       o_RespErr;

    always #5 clk = ~clk;

    msi_directory_controller dut (
        .i_Clock(clk), .i_Reset(i_Reset),
        .i_ReqValid(i_ReqValid), .o_ReqReady(o_ReqReady),
        .i_ReqProc(i_ReqProc), .i_ReqOp(i_ReqOp),
        .i_ReqAddress(i_ReqAddress), .i_ReqData(i_ReqData),
        .o_MemValid(o_MemValid), .o_MemWrite(o_MemWrite),
        .o_MemAddress(o_MemAddress), .o_MemWriteData(o_MemWriteData),
        .i_MemAck(i_MemAck), .i_MemReadData(i_MemReadData),
        .o_InvValid(o_InvValid), .o_InvMask(o_InvMask),
        .o_FetchValid(o_FetchValid), .o_FetchProc(o_FetchProc),
        .o_FetchInv(o_FetchInv), .i_FetchAck(i_FetchAck),
        .i_FetchData(i_FetchData),
        .o_RespValid(o_RespValid), .o_RespProc(o_RespProc),
        .o_RespAddress(o_RespAddress), .o_RespData(o_RespData),
        .o_RespErr(o_RespErr)
    );

    int n_chk = 0;
    int n_bad = 0;
    // Model: 0 Invalid, 1 Shared, 2 Modified; sharers as a bitmask
    int m_st [8];
    int m_own [8];
    int m_shr [8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_st[i] = 0; m_own[i] = 0; m_shr[i] = 0;
        end
    endtask

    task automatic run_req(input int p, input int op, input int a, input int d,
                           input int fdel, input int mlat,
                           input int fd, input int md);
        int bad, i, rb, e_err, e_invst, e_mask, e_fetch, e_fp, e_finv;
        int e_mem, e_wr, e_wdata, e_rdata, e_lat, e_fcyc;
        int n_st, n_own, n_shr;
        int mcnt, fcnt, icnt, rcnt, lat, stable, done;
        logic       g_wr, g_fi, g_re;
        logic [3:0] g_ma, g_md, g_ra, g_rd;
        logic [1:0] g_fp, g_rp;
        logic [2:0] g_im;
        int g_lat;

        bad = (a == 0 || a > 8 || op == 3 || p >= 3) ? 1 : 0;
        i = bad ? 0 : a - 1;
        rb = (p < 3) ? (1 << p) : 0;
        e_err = 1; e_invst = 0; e_mask = 0; e_fetch = 0; e_fp = 0; e_finv = 0;
        e_mem = 0; e_wr = 0; e_wdata = 0; e_rdata = 0;
        n_st = m_st[i]; n_own = m_own[i]; n_shr = m_shr[i];
        if (!bad) begin
            if (op == 0 && m_st[i] == 2 && m_own[i] != p) begin
                e_err = 0; e_fetch = 1; e_fp = m_own[i]; e_finv = 0;
                e_mem = 1; e_wr = 1; e_wdata = fd; e_rdata = fd;
                n_st = 1; n_shr = (1 << m_own[i]) | rb;
            end else if (op == 0 && m_st[i] != 2) begin
                e_err = 0; e_mem = 1; e_rdata = md;
                n_st = 1; n_shr = m_shr[i] | rb;
            end else if (op == 1 && m_st[i] == 2 && m_own[i] != p) begin
                e_err = 0; e_fetch = 1; e_fp = m_own[i]; e_finv = 1;
                e_mem = 1; e_wr = 1; e_wdata = fd; e_rdata = fd;
                n_st = 2; n_own = p; n_shr = rb;
            end else if (op == 1 && m_st[i] != 2) begin
                e_err = 0; e_mem = 1; e_rdata = md;
                if (m_st[i] == 1) begin
                    e_invst = 1; e_mask = m_shr[i] & ~rb & 7;
                end
                n_st = 2; n_own = p; n_shr = rb;
            end else if (op == 2 && m_st[i] == 2 && m_own[i] == p) begin
                e_err = 0; e_mem = 1; e_wr = 1; e_wdata = d; e_rdata = d;
                n_st = 0; n_own = 0; n_shr = 0;
            end
        end
        e_fcyc = e_fetch ? ((fdel < 0) ? 15 : fdel + 1) : 0;
        if (e_fetch && fdel < 0) begin
            e_err = 1; e_mem = 0;
        end
        e_lat = 1 + e_invst + e_fcyc + (e_mem ? mlat + 1 : 0) + 1;

        i_ReqValid = 1'b1;
        i_ReqProc = 2'(p); i_ReqOp = 2'(op);
        i_ReqAddress = 4'(a); i_ReqData = 4'(d);
        chk("req_ready", o_ReqReady, 1);
        @(negedge clk);
        i_ReqProc = 2'($urandom); i_ReqOp = 2'($urandom);
        i_ReqAddress = 4'($urandom); i_ReqData = 4'($urandom);
        mcnt = 0; fcnt = 0; icnt = 0; rcnt = 0; lat = 1; stable = 1; done = 0;
        g_wr = 0; g_fi = 0; g_re = 0; g_ma = 0; g_md = 0; g_ra = 0; g_rd = 0;
        g_fp = 0; g_rp = 0; g_im = 0; g_lat = 0;
        for (int c = 0; c < 60 && done == 0; c++) begin
            i_ReqValid = 1'($urandom);
            if (o_MemValid) begin
                mcnt++;
                if (mcnt == 1) begin
                    g_wr = o_MemWrite; g_ma = o_MemAddress; g_md = o_MemWriteData;
                end else if (o_MemWrite !== g_wr || o_MemAddress !== g_ma ||
                             o_MemWriteData !== g_md) begin
                    stable = 0;
                end
                i_MemAck = (mcnt == mlat + 1);
                i_MemReadData = 4'(md);
            end else begin
                i_MemAck = ($urandom_range(0, 3) == 0);
                i_MemReadData = 4'($urandom);
            end
            if (o_FetchValid) begin
                fcnt++;
                g_fp = o_FetchProc; g_fi = o_FetchInv;
                i_FetchAck = (fcnt == fdel + 1);
                i_FetchData = 4'(fd);
            end else begin
                i_FetchAck = ($urandom_range(0, 3) == 0);
                i_FetchData = 4'($urandom);
            end
            if (o_InvValid) begin
                icnt++;
                g_im = o_InvMask;
            end
            if (o_RespValid) begin
                rcnt++;
                g_lat = lat; g_rp = o_RespProc; g_ra = o_RespAddress;
                g_rd = o_RespData; g_re = o_RespErr;
                i_ReqValid = 1'b0; i_MemAck = 1'b0; i_FetchAck = 1'b0;
                @(negedge clk);
                chk("ready_after_resp", o_ReqReady, 1);
                chk("resp_single_pulse", o_RespValid, 0);
                done = 1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        i_ReqValid = 1'b0;
        chk("resp_seen", rcnt, 1);
        if (rcnt == 1) begin
            chk("resp_err", g_re, e_err);
            chk("resp_proc", g_rp, p & 3);
            chk("resp_addr", g_ra, a & 15);
            chk("resp_latency", g_lat, e_lat);
            if (!e_err) chk("resp_data", g_rd, e_rdata);
        end
        chk("mem_cycles", mcnt, e_mem ? mlat + 1 : 0);
        if (e_mem) begin
            chk("mem_write", g_wr, e_wr);
            chk("mem_addr", g_ma, a);
            if (e_wr) chk("mem_wdata", g_md, e_wdata);
            chk("mem_stable", stable, 1);
        end
        chk("inv_pulses", icnt, (e_mask != 0) ? 1 : 0);
        if (e_mask != 0) chk("inv_mask", g_im, e_mask);
        chk("fetch_cycles", fcnt, e_fcyc);
        if (e_fetch) begin
            chk("fetch_proc", g_fp, e_fp);
            chk("fetch_inv", g_fi, e_finv);
        end
        if (!e_err) begin
            m_st[i] = n_st; m_own[i] = n_own; m_shr[i] = n_shr;
        end
    endtask

    task automatic reset_mid_read(input int a);
        int seen;
        i_ReqValid = 1'b1; i_ReqProc = 2'd0; i_ReqOp = 2'd0;
        i_ReqAddress = 4'(a); i_ReqData = 4'd0;
        @(negedge clk);
        i_ReqValid = 1'b0;
        seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            if (o_MemValid) seen = 1;
            else @(negedge clk);
        end
        chk("rst_memvalid_seen", seen, 1);
        i_Reset = 1'b1; i_MemAck = 1'b0;
        @(negedge clk);
        chk("rst_memvalid_drop", o_MemValid, 0);
        chk("rst_no_resp", o_RespValid, 0);
        chk("rst_ready_low", o_ReqReady, 0);
        chk("rst_fetch_low", o_FetchValid, 0);
        i_Reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_back", o_ReqReady, 1);
        chk("rst_no_resp_after", o_RespValid, 0);
        clear_model();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, op, a, fdel, r;
        clear_model();
        repeat (2) @(negedge clk);
        chk("reset_ready", o_ReqReady, 0);
        chk("reset_memvalid", o_MemValid, 0);
        chk("reset_respvalid", o_RespValid, 0);
        chk("reset_invvalid", o_InvValid, 0);
        chk("reset_fetchvalid", o_FetchValid, 0);
        i_Reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", o_ReqReady, 1);

        run_req(0, 0, 1, 0, 0, 1, 0, 4'b0010);
        run_req(1, 0, 1, 0, 0, 0, 0, 5);
        run_req(2, 1, 1, 0, 0, 1, 0, 6);
        run_req(0, 0, 1, 0, 2, 0, 4'b1001, 3);
        run_req(2, 1, 1, 0, 0, 0, 0, 4);
        run_req(2, 2, 1, 4'b0111, 0, 0, 0, 0);
        run_req(2, 2, 1, 4'b0111, 0, 0, 0, 0);
        run_req(0, 0, 0, 0, 0, 0, 0, 1);
        run_req(0, 0, 9, 0, 0, 0, 0, 1);
        run_req(0, 3, 2, 0, 0, 0, 0, 1);
        run_req(3, 0, 2, 0, 0, 0, 0, 1);
        run_req(1, 1, 2, 0, 0, 0, 0, 3);
        run_req(0, 0, 2, 0, -1, 0, 5, 0);
        run_req(0, 0, 2, 0, 14, 0, 6, 0);
        reset_mid_read(5);
        for (int k = 1; k <= 8; k++)
            run_req(0, 1, k, 0, 0, $urandom_range(0, 3), 0, $urandom_range(0, 15));

        for (int n = 0; n < 400; n++) begin
            p = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            op = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15)
                                            : $urandom_range(1, 8);
            if (op == 2 && a >= 1 && a <= 8 && m_st[a-1] == 2 &&
                $urandom_range(0, 1) == 1)
                p = m_own[a-1];
            r = $urandom_range(0, 19);
            fdel = (r < 15) ? r : ((r < 18) ? $urandom_range(0, 3) : -1);
            run_req(p, op, a, $urandom_range(0, 15), fdel, $urandom_range(0, 3),
                    $urandom_range(0, 15), $urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/msi_directory_controller.md
Name: msi_directory_controller

Overview:
- Home-node directory for the 8-block MSI system; the requesting end of the memory interface that the main memory responds to.
- Accepts read-miss, write-miss and writeback requests from up to three processor caches.
- Tracks per-block MSI state, sharer set and owner. Issues memory reads and writebacks, invalidations and owner fetches, then returns one response per request.

Parameters:
- NPROC, 3, number of processor caches (sharer mask width).
- NBLK, 8, directory entries; valid addresses 1..NBLK, index = address-1.
- FETCH_TIMEOUT, 15, max cycles waited for FetchAck before an error response.

Ports:
- Clock  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  1  request present.
- ReqReady  out  1  high only in IDLE and not in reset.
- ReqProc  in  2  requesting processor, 0..NPROC-1.
- ReqOp  in  2  00 read miss, 01 write miss, 10 writeback, 11 reserved (error).
- ReqAddress  in  4  block address.
- ReqData  in  4  writeback data.
- MemValid  out  1  memory request, held until MemAck.
- MemWrite  out  1  1 = write, 0 = read.
- MemAddress  out  4  memory address.
- MemWriteData  out  4  write data.
- MemAck  in  1  one-cycle completion; MemReadData valid in the same cycle.
- MemReadData  in  4  read data.
- InvValid  out  1  one-cycle invalidate pulse.
- InvMask  out  NPROC  caches to invalidate.
- FetchValid  out  1  owner fetch, held until FetchAck or timeout.
- FetchProc  out  2  owner being fetched.
- FetchInv  out  1  owner must also invalidate (write miss).
- FetchAck  in  1  owner data returned.
- FetchData  in  4  owner's dirty data.
- RespValid  out  1  one-cycle response pulse.
- RespProc  out  2  destination processor.
- RespAddress  out  4  echoed address.
- RespData  out  4  block data.
- RespErr  out  1  request rejected; directory unchanged.

Behaviour:
- Reset: all outputs 0 except ReqReady (0 during reset, 1 on the first cycle after). Every entry goes to Invalid with sharers 0 and owner 0.
- Reset mid-transaction: abort with no response. MemValid and FetchValid drop at the reset edge. The directory is cleared.
- States: IDLE, LOOKUP, INV, FETCH, MEM_WB, MEM_RD, RESPOND.
- IDLE: on ReqValid && ReqReady, latch proc, op, address and data, then go to LOOKUP. ReqValid outside IDLE is ignored.
- LOOKUP: if the address is 0 or >NBLK, ReqOp=11, or ReqProc>=NPROC, go to RESPOND with RespErr=1. Otherwise dispatch on op and entry state:
  - Read, Invalid -> MEM_RD. On completion: Shared, sharers={req}.
  - Read, Shared -> MEM_RD. On completion: sharers |= req.
  - Read, Modified with owner O!=req -> FETCH (FetchInv=0) -> MEM_WB with FetchData. Result: Shared, sharers={O,req}, RespData=FetchData.
  - Write, Invalid -> MEM_RD. Result: Modified, owner=req, sharers={req}.
  - Write, Shared -> INV, pulsing InvValid with InvMask=sharers&~req. If that mask is 0, no pulse. Then MEM_RD. Result: Modified, owner=req.
  - Write, Modified with O!=req -> FETCH (FetchInv=1) -> MEM_WB. Result: Modified, owner=req, RespData=FetchData.
  - Writeback, Modified with owner==req -> MEM_WB with ReqData. Result: Invalid, sharers 0, RespData=ReqData.
  - Read or write, Modified with owner==req: protocol error, RespErr=1.
  - Writeback not from the owner: protocol error, RespErr=1.
- Memory handshake:
  - MemValid, MemWrite, MemAddress and MemWriteData are stable from state entry until the cycle MemAck=1.
  - The FSM advances on the edge after MemAck. MemAck while MemValid=0 is ignored.
  - MEM_RD latches MemReadData into RespData.
- FETCH:
  - The counter starts at 0 and increments each cycle without FetchAck.
  - FetchAck latches FetchData.
  - When the counter reaches FETCH_TIMEOUT: RespErr=1, directory unchanged, go to RESPOND.
  - FetchAck in the same cycle the counter reaches FETCH_TIMEOUT counts as success.
- Directory update commits only on the RESPOND entry edge, and only when RespErr=0.
- RESPOND: a single RespValid pulse, then IDLE. ReqReady is 1 on the following cycle.
- Latency: read of an Invalid block with MemAck one cycle after MemValid gives RespValid 4 cycles after the accept edge. Back-to-back requests are accepted every response+1 cycles.

Test Plan:
- Reset, then P0 reads 0001. MemValid=1, MemWrite=0, MemAddress=0001; MemReadData=0010 with ack. Expect RespValid, RespProc=0, RespData=0010, 4 cycles after accept. Entry 0 Shared, sharers=001.
- P1 reads 0001, then P2 writes 0001. Expect an InvValid pulse with InvMask=011, then a memory read. Entry goes to Modified, owner 2.
- P0 reads 0001 while P2 owns it. Expect FetchValid, FetchProc=2, FetchInv=0. FetchData=1001, then a memory write of 0001/1001. Resp to P0 with data 1001; sharers=101.
- P2 writes back 0001 with data 0111 while owner. Expect a memory write 0001/0111, and RespData=0111. Entry Invalid. A second writeback from P2 gives RespErr=1.
- Request for address 0000 or 1001, or ReqOp=11. Expect RespErr=1, no MemValid, directory unchanged.
- Fetch with FetchAck withheld. Expect RespErr=1 after 15 cycles. Separately, assert Reset during MEM_RD: MemValid=0 next cycle, no RespValid, all entries Invalid.
